// File: rtl/bconv_kxk_engine.sv
// bconv_kxk_engine
//   Binary (XNOR/popcount) valid convolution engine with a runtime kernel
//   size K in 1..KMAX. It reads the frame header and image rows from the
//   input SRAM, reads K bit-packed kernel rows from weight memory, and writes
//   one bit-packed output word per output row back to SRAM.
//
// Ports
//   clk, reset_b                 clock, synchronous active-low reset
//   dut_run                      start request (honoured in IDLE only)
//   dut_busy                     high from start-accept until frame complete
//   dut_sram_read_address/_data  input SRAM read port (1-cycle read latency)
//   dut_wmem_read_address/_data  weight memory read port (1-cycle latency)
//   dut_sram_write_address/_data/_enable  output row write port
//   cfg_err                      sticky illegal-configuration flag
module bconv_kxk_engine #(
  parameter int                ROW_W    = 16,
  parameter int                KMAX     = 5,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] OUT_BASE = '0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [ROW_W-1:0]  sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [ROW_W-1:0]  wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [ROW_W-1:0]  dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic              cfg_err
);

  localparam int KW    = $clog2(KMAX + 1);
  localparam int CNT_W = $clog2(KMAX * KMAX + 1);
  localparam int CW    = $clog2(ROW_W);
  localparam int IW    = (KW < 2) ? 2 : KW;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CFG, S_CHECK, S_RD_W, S_FILL, S_COMPUTE, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_err;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [ADDR_W-1:0] r_wmem_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ROW_W-1:0]  r_wr_data;
  logic              r_wr_en;
  logic [ROW_W-1:0]  r_k;
  logic [ROW_W-1:0]  r_nrows;
  logic [ROW_W-1:0]  r_ncols;
  logic [ROW_W-1:0]  r_w   [KMAX];
  logic [ROW_W-1:0]  r_win [KMAX];
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     r_last_col;
  logic [ROW_W-1:0]  r_out_row;
  logic [ROW_W-1:0]  r_acc;

  logic [KW-1:0]     w_k;
  logic [KMAX-1:0]   w_win_sh;
  logic              w_xn;
  logic [CNT_W-1:0]  w_match;
  logic              w_bit;
  logic [ROW_W-1:0]  w_acc_next;
  logic              w_cfg_bad;

  assign dut_busy               = r_busy;
  assign cfg_err                = r_err;
  assign dut_sram_read_address  = r_sram_addr;
  assign dut_wmem_read_address  = r_wmem_addr;
  assign dut_sram_write_address = r_wr_addr;
  assign dut_sram_write_data    = r_wr_data;
  assign dut_sram_write_enable  = r_wr_en;

  // K is only used narrowed once the configuration has been checked legal.
  assign w_k = r_k[KW-1:0];

  // Window match count for output column r_col; rows/columns >= K are ignored.
  always_comb begin
    w_match  = '0;
    w_win_sh = '0;
    w_xn     = 1'b0;
    for (int i = 0; i < KMAX; i++) begin
      w_win_sh = KMAX'(r_win[i] >> r_col);
      for (int j = 0; j < KMAX; j++) begin
        w_xn = w_win_sh[j] ~^ r_w[i][j];
        if ((i < int'(w_k)) && (j < int'(w_k)) && w_xn)
          w_match = w_match + CNT_W'(1);
      end
    end
  end

  // Output bit is 1 when the +/-1 correlation is non-negative.
  always_comb begin
    w_bit             = (2 * int'(w_match)) >= (int'(w_k) * int'(w_k));
    w_acc_next        = r_acc;
    w_acc_next[r_col] = w_bit;
  end

  assign w_cfg_bad = (r_k == '0) || (r_k > ROW_W'(KMAX)) ||
                     (r_ncols > ROW_W'(ROW_W)) || (r_ncols < r_k) || (r_nrows < r_k);

  // Controller and datapath. Reads are issued one per cycle and the data
  // for the address issued at edge n is captured at edge n+2, which is why
  // RD_W/FILL capture element r_idx-1 and run for K+1 cycles.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_sram_addr <= '0;
      r_wmem_addr <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_k         <= '0;
      r_nrows     <= '0;
      r_ncols     <= '0;
      r_idx       <= '0;
      r_col       <= '0;
      r_last_col  <= '0;
      r_out_row   <= '0;
      r_acc       <= '0;
      for (int i = 0; i < KMAX; i++) begin
        r_w[i]   <= '0;
        r_win[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dut_run) begin
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_sram_addr <= '0;
            r_wmem_addr <= '0;
            r_idx       <= '0;
            r_state     <= S_RD_CFG;
          end
        end
        S_RD_CFG: begin
          r_idx <= r_idx + IW'(1);
          if (r_idx == IW'(0)) begin
            r_sram_addr <= ADDR_W'(1);
          end else if (r_idx == IW'(1)) begin
            r_k     <= wmem_dut_read_data;
            r_nrows <= sram_dut_read_data;
          end else begin
            r_ncols <= sram_dut_read_data;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_last_col  <= CW'(r_ncols - r_k);
            r_out_row   <= '0;
            r_wmem_addr <= ADDR_W'(1);
            r_idx       <= '0;
            r_state     <= S_RD_W;
          end
        end
        S_RD_W: begin
          r_wmem_addr <= r_wmem_addr + ADDR_W'(1);
          r_idx       <= r_idx + IW'(1);
          if (r_idx != '0)
            r_w[r_idx - IW'(1)] <= wmem_dut_read_data;
          if (r_idx == IW'(w_k)) begin
            r_idx       <= '0;
            r_sram_addr <= ADDR_W'(2);
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          r_idx       <= r_idx + IW'(1);
          r_sram_addr <= r_sram_addr + ADDR_W'(1);
          if (r_idx != '0)
            r_win[r_idx - IW'(1)] <= sram_dut_read_data;
          if (r_idx == IW'(w_k)) begin
            // Prefetch row K now so ADVANCE finds it already on the bus.
            r_sram_addr <= ADDR_W'(2) + ADDR_W'(w_k);
            r_col       <= '0;
            r_acc       <= '0;
            r_state     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_next;
          if (r_col == r_last_col) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= OUT_BASE + ADDR_W'(r_out_row);
            r_wr_data <= w_acc_next;
            r_state   <= S_WRITE;
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        S_WRITE: begin
          r_wr_en   <= 1'b0;
          r_out_row <= r_out_row + ROW_W'(1);
          if (r_out_row == (r_nrows - r_k))
            r_state <= S_DONE;
          else
            r_state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          for (int i = 0; i < KMAX - 1; i++) begin
            if (i < int'(w_k) - 1)
              r_win[i] <= r_win[i + 1];
          end
          r_win[w_k - KW'(1)] <= sram_dut_read_data;
          r_sram_addr         <= r_sram_addr + ADDR_W'(1);
          r_acc               <= '0;
          r_col               <= '0;
          r_state             <= S_COMPUTE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
